// File: rtl/execute_unit.sv
// Execute stage behind the 16x8 register file: single-cycle ALU plus an optional
// shift-add multiplier, enabled by defining EXEC_UNIT_MUL_EN.
module execute_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    output logic              wb_n_w,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    output logic              illegal_op
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
`ifdef EXEC_UNIT_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hC;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W - 1);
`endif

    logic [ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_n_w;
    logic [3:0]        r_flags;
    logic              r_illegal;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_upd_nz;
    logic              w_upd_cv;
    logic              w_wr;
    logic              w_illegal;
    logic              w_accept;
    logic              w_start_mul;

`ifdef EXEC_UNIT_MUL_EN
    logic [0:0]          r_state;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mul_rd;
    logic [2*DATA_W-1:0] w_acc_next;

    assign in_ready   = (r_state == ST_IDLE);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`else
    assign in_ready   = 1'b1;
`endif

    assign w_accept = in_valid & in_ready;
    assign w_sum    = {1'b0, rs_data} + {1'b0, rt_data};
    // The extra top bit of the difference is the unsigned borrow.
    assign w_diff   = {1'b0, rs_data} - {1'b0, rt_data};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_res       = '0;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_upd_nz    = 1'b0;
        w_upd_cv    = 1'b0;
        w_wr        = 1'b0;
        w_illegal   = 1'b0;
        w_start_mul = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                w_res    = w_sum[MSB:0];
                w_c      = w_sum[DATA_W];
                w_v      = (rs_data[MSB] == rt_data[MSB]) && (w_sum[MSB] != rs_data[MSB]);
                w_upd_nz = 1'b1;
                w_upd_cv = 1'b1;
                w_wr     = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                w_res    = w_diff[MSB:0];
                w_c      = w_diff[DATA_W];
                w_v      = (rs_data[MSB] != rt_data[MSB]) && (w_diff[MSB] != rs_data[MSB]);
                w_upd_nz = 1'b1;
                w_upd_cv = 1'b1;
                w_wr     = (opcode == OP_SUB);
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                case (opcode)
                    OP_AND:  w_res = rs_data & rt_data;
                    OP_OR:   w_res = rs_data | rt_data;
                    OP_XOR:  w_res = rs_data ^ rt_data;
                    default: w_res = ~rs_data;
                endcase
                w_upd_nz = 1'b1;
                w_upd_cv = 1'b1;
                w_wr     = 1'b1;
            end
            OP_SHL: begin
                w_res    = {rs_data[MSB-1:0], 1'b0};
                w_c      = rs_data[MSB];
                w_upd_nz = 1'b1;
                w_upd_cv = 1'b1;
                w_wr     = 1'b1;
            end
            OP_SHR: begin
                w_res    = {1'b0, rs_data[MSB:1]};
                w_c      = rs_data[0];
                w_upd_nz = 1'b1;
                w_upd_cv = 1'b1;
                w_wr     = 1'b1;
            end
            OP_MOV, OP_LDI: begin
                w_res    = (opcode == OP_MOV) ? rt_data : imm;
                w_upd_nz = 1'b1;
                w_wr     = 1'b1;
            end
`ifdef EXEC_UNIT_MUL_EN
            OP_MUL: w_start_mul = 1'b1;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // NOTE: state is assigned with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wb_n_w  <= 1'b1;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_mul_rd  <= '0;
`endif
        end else begin
            r_wb_n_w  <= 1'b1;
            r_illegal <= 1'b0;
            if (w_accept) begin
`ifdef EXEC_UNIT_MUL_EN
                if (w_start_mul) begin
                    r_state  <= ST_MUL;
                    r_acc    <= '0;
                    r_mcand  <= {{DATA_W{1'b0}}, rs_data};
                    r_mplier <= rt_data;
                    r_cnt    <= CNT_INIT;
                    r_mul_rd <= rd;
                end
`endif
                if (w_upd_nz) begin
                    r_flags[3] <= w_res[MSB];
                    r_flags[2] <= (w_res == '0);
                end
                if (w_upd_cv) begin
                    r_flags[1] <= w_c;
                    r_flags[0] <= w_v;
                end
                // R0 is hard zero, so writes to it are dropped.
                if (w_wr && (rd != '0)) begin
                    r_wb_n_w  <= 1'b0;
                    r_wb_rd   <= rd;
                    r_wb_data <= w_res;
                end
                r_illegal <= w_illegal;
            end
`ifdef EXEC_UNIT_MUL_EN
            else if (r_state == ST_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[MSB:1]};
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_state    <= ST_IDLE;
                    r_flags[3] <= w_acc_next[MSB];
                    r_flags[2] <= (w_acc_next[MSB:0] == '0);
                    r_flags[1] <= |w_acc_next[2*DATA_W-1:DATA_W];
                    r_flags[0] <= 1'b0;
                    if (r_mul_rd != '0) begin
                        r_wb_n_w  <= 1'b0;
                        r_wb_rd   <= r_mul_rd;
                        r_wb_data <= w_acc_next[MSB:0];
                    end
                end
            end
`endif
        end
    end

    assign wb_n_w     = r_wb_n_w;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign flags      = r_flags;
    assign illegal_op = r_illegal;

endmodule
